mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset; ports below, clock and reset first.
REQ-002 clk_i  in  1  rising-edge clock.
REQ-003 rst_n_i  in  1  asynchronous active-low reset.
REQ-004 valid_i, memread_i, memwrite_i  in  1 each  EX_MEM entry valid, load request, store request.
REQ-005 addr_i, wdata_i  in  32 each  ALU result used as address, store data.
REQ-006 wb_i [1:0], writeaddr_i [4:0]  in  writeback controls and destination register from EX_MEM.
REQ-007 size_i [1:0], sign_i  in  access size (00 byte, 01 half, 10 word) and load sign-extend; present only under DMEM_SUBWORD_EN.
REQ-008 dmem_req_o, dmem_we_o  out  1 each  memory request and write strobe.
REQ-009 dmem_addr_o, dmem_wdata_o  out  32 each  word-aligned address ({addr_i[31:2],2'b00}) and store data.
REQ-010 dmem_be_o  out  4  byte enables.
REQ-011 dmem_ack_i  in  1; dmem_rdata_i  in  32  memory completion and read data.
REQ-012 memdata_o, aluresult_o  out  32 each; wb_o  out  2; writeaddr_o  out  5  feed the MEM_WB register.
REQ-013 stall_o  out  1  freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB while high.
REQ-014 misalign_o, bus_err_o  out  1 each  single-cycle error pulses.

Function
REQ-015 FSM states IDLE, ACCESS, with the current access decided in IDLE and held in ACCESS.
REQ-016 IDLE: valid_i & (memread_i|memwrite_i) & aligned -> ACCESS next cycle; dmem_req_o is asserted from the first ACCESS cycle, not combinationally in IDLE.
REQ-017 stall_o = (IDLE & start) | (ACCESS & ~dmem_ack_i), combinational.
REQ-018 ACCESS: dmem_req_o=1, request fields stable from registered copies until ack; on dmem_ack_i -> IDLE the same edge.
REQ-019 Minimum load/store latency 2 cycles (start cycle + ack cycle); each extra wait cycle adds one.
REQ-020 memdata_o = formatted dmem_rdata_i in the ack cycle; 0 otherwise.
REQ-021 aluresult_o = addr_i, writeaddr_o = writeaddr_i, and wb_o = wb_i, except where REQ-023/025 force wb_o.
REQ-022 Non-memory or invalid entries pass through with stall_o=0 and no request.
REQ-023 Misaligned access (word addr[1:0]!=0; half addr[0]!=0) -> no request, misalign_o=1 one cycle, wb_o=00, no stall.
REQ-024 8-bit wait counter cleared on entering ACCESS, increments each ACCESS cycle without ack.
REQ-025 Counter reaching TIMEOUT_CYC (255) with no ack -> dmem_req_o drops, bus_err_o=1 one cycle, wb_o=00, stall_o=0, state IDLE.
REQ-026 Ack and timeout in the same cycle -> ack wins, no bus_err_o.
REQ-027 dmem_ack_i in IDLE is ignored.

Reset
REQ-028 rst_n_i low -> state IDLE, counter 0, dmem_req_o/dmem_we_o=0, dmem_be_o=0, error pulses 0, immediately (asynchronous).
REQ-029 Reset mid-ACCESS abandons the transaction; a late ack after reset release is ignored.

Configuration
REQ-030 Macro DMEM_SUBWORD_EN defined: size_i/sign_i exist; byte/half stores replicate data across lanes with matching dmem_be_o; loads extract by addr[1:0] and sign-extend or zero-extend.
REQ-031 DMEM_SUBWORD_EN undefined: every access is a word access, dmem_be_o=4'hF during requests, memdata_o=dmem_rdata_i, and only addr[1:0]!=0 is misaligned.

Structure
REQ-032 Package mem_pkg SHALL hold the state enum, the size encodings, and TIMEOUT_CYC.
REQ-033 Load formatting SHALL be one sub-module, mem_load_fmt (rdata, addr[1:0], size, sign -> memdata).

Verification
REQ-034 Load addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles, memdata_o=0xDEADBEEF in the ack cycle, wb_o=wb_i.
REQ-035 Store addr 0x204, wdata 0x12345678, immediate ack -> dmem_we_o=1, be=4'hF, stall exactly 1 cycle.
REQ-036 Word load addr 0x102 -> misalign_o pulse, wb_o=00, no dmem_req_o, no stall.
REQ-037 No ack for 255 ACCESS cycles -> bus_err_o pulse, req drops, stall releases, next load completes normally.
REQ-038 rst_n_i low mid-ACCESS -> req=0 immediately; an ack 2 cycles after release produces no memdata or state change.
REQ-039 DMEM_SUBWORD_EN defined: lb addr 0x103, rdata 0x80FFFFFF -> memdata_o=0xFFFFFF80; lbu -> 0x00000080; sb addr 0x101 data 0xAB -> be=4'b0010, wdata 0xABABABAB.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, size encodings and helpers for the data-memory access stage.
// Sub-word helpers only matter when DMEM_SUBWORD_EN is defined; otherwise every access is a word.
package mem_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [7:0] TIMEOUT_CYC = 8'd255;

    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~off[0];
            default:   ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'hF;
        endcase
        return be;
    endfunction

    // Narrow stores are replicated so the enabled lane always carries the data.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{data[7:0]}};
            SIZE_HALF: lanes = {2{data[15:0]}};
            default:   lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load data formatter: selects the addressed byte/half of the read word and sign- or zero-extends it.
module mem_load_fmt
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] memdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_BYTE: memdata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            SIZE_HALF: memdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default:   memdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives one data-memory request per load/store and stalls the pipe until ack or timeout.
// Optional byte/half accesses are enabled with the DMEM_SUBWORD_EN macro.
//
// state     | meaning
// ST_IDLE   | access decided from EX_MEM inputs; a valid aligned load/store starts a request
// ST_ACCESS | request held from registered fields until dmem_ack_i or wait-counter timeout
module mem_access
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  wb_i,
    input  logic [4:0]  writeaddr_i,
`ifdef DMEM_SUBWORD_EN
    input  logic [1:0]  size_i,
    input  logic        sign_i,
`endif
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] memdata_o,
    output logic [31:0] aluresult_o,
    output logic [1:0]  wb_o,
    output logic [4:0]  writeaddr_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;

    logic [1:0]  size_in;
    logic        sign_in;
    logic        is_mem, aligned, start, timeout;
    logic [31:0] fmt_data;

`ifdef DMEM_SUBWORD_EN
    assign size_in = size_i;
    assign sign_in = sign_i;
`else
    assign size_in = SIZE_WORD;
    assign sign_in = 1'b0;
`endif

    assign is_mem  = valid_i & (memread_i | memwrite_i);
    assign aligned = addr_aligned(size_in, addr_i[1:0]);
    assign start   = is_mem & aligned;
    assign timeout = (state_q == ST_ACCESS) & ~dmem_ack_i & (cnt_q == TIMEOUT_CYC);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            off_q   <= '0;
            size_q  <= SIZE_WORD;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        off_d   = off_q;
        size_d  = size_q;
        sign_d  = sign_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
                addr_d  = addr_i[31:2];
                wdata_d = store_lanes(size_in, wdata_i);
                we_d    = memwrite_i;
                be_d    = byte_enable(size_in, addr_i[1:0]);
                off_d   = addr_i[1:0];
                size_d  = size_in;
                sign_d  = sign_in;
            end
        end else if (dmem_ack_i || timeout) begin
            state_d = ST_IDLE;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Ack in the timeout cycle wins because timeout already excludes dmem_ack_i.
    always_comb begin
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        dmem_be_o  = 4'h0;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        wb_o       = wb_i;
        if (state_q == ST_IDLE) begin
            stall_o    = start;
            misalign_o = is_mem & ~aligned;
            if (is_mem && !aligned) begin
                wb_o = 2'b00;
            end
        end else begin
            dmem_req_o = 1'b1;
            dmem_we_o  = we_q;
            dmem_be_o  = be_q;
            stall_o    = ~dmem_ack_i & ~timeout;
            bus_err_o  = timeout;
            if (timeout) begin
                wb_o = 2'b00;
            end
        end
    end

    mem_load_fmt u_load_fmt (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (off_q),
        .size_i    (size_q),
        .sign_i    (sign_q),
        .memdata_o (fmt_data)
    );

    assign memdata_o    = ((state_q == ST_ACCESS) && dmem_ack_i) ? fmt_data : 32'h0;
    assign dmem_addr_o  = {addr_q, 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign aluresult_o  = addr_i;
    assign writeaddr_o  = writeaddr_i;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level reference model, per-cycle compare, directed literals.
// Define DMEM_SUBWORD_EN to also exercise byte/half accesses.
module tb_mem_access;

    localparam int TMO    = 255;
    localparam int NO_ACK = 1000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i, memread_i, memwrite_i;
    logic [31:0] addr_i, wdata_i;
    logic [1:0]  wb_i;
    logic [4:0]  writeaddr_i;
`ifdef DMEM_SUBWORD_EN
    logic [1:0]  size_i;
    logic        sign_i;
`endif
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] memdata_o, aluresult_o;
    logic [1:0]  wb_o;
    logic [4:0]  writeaddr_o;
    logic        stall_o, misalign_o, bus_err_o;

    logic        exp_req, exp_we, exp_stall, exp_mis, exp_berr;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_memdata, exp_alu;
    logic [1:0]  exp_wb;
    logic [4:0]  exp_wa;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          check_en = 1'b0;
    int          stall_cnt, req_cnt, mis_cnt, berr_cnt;
    logic [31:0] ack_memdata, ack_wdata;
    logic [3:0]  ack_be;
    logic        ack_we;

    mem_access dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wb_i         (wb_i),
        .writeaddr_i  (writeaddr_i),
`ifdef DMEM_SUBWORD_EN
        .size_i       (size_i),
        .sign_i       (sign_i),
`endif
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .memdata_o    (memdata_o),
        .aluresult_o  (aluresult_o),
        .wb_o         (wb_o),
        .writeaddr_o  (writeaddr_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input int n, input logic sg);
        logic [31:0] v, mask;
        if (n == 4) return rd;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rd >> (8 * int'(a[1:0]))) & mask;
        if (sg && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input int n, input logic [31:0] a);
        return 4'((((1 << n) - 1) << int'(a[1:0])) & 15);
    endfunction

    function automatic logic [31:0] ref_wdata(input int n, input logic [31:0] d);
        if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    always @(negedge clk_i) begin
        if (check_en) begin
            chk("req", 32'(dmem_req_o), 32'(exp_req));
            chk("we", 32'(dmem_we_o), 32'(exp_we));
            chk("be", 32'(dmem_be_o), 32'(exp_be));
            chk("stall", 32'(stall_o), 32'(exp_stall));
            chk("misalign", 32'(misalign_o), 32'(exp_mis));
            chk("bus_err", 32'(bus_err_o), 32'(exp_berr));
            chk("memdata", memdata_o, exp_memdata);
            chk("aluresult", aluresult_o, exp_alu);
            chk("wb", 32'(wb_o), 32'(exp_wb));
            chk("writeaddr", 32'(writeaddr_o), 32'(exp_wa));
            if (exp_req) begin
                chk("addr", dmem_addr_o, exp_addr);
                chk("wdata", dmem_wdata_o, exp_wdata);
            end
            stall_cnt += int'(stall_o);
            req_cnt   += int'(dmem_req_o);
            mis_cnt   += int'(misalign_o);
            berr_cnt  += int'(bus_err_o);
            if (dmem_req_o && dmem_ack_i) begin
                ack_memdata = memdata_o;
                ack_wdata   = dmem_wdata_o;
                ack_be      = dmem_be_o;
                ack_we      = dmem_we_o;
            end
        end
    end

    task automatic clr_mon();
        stall_cnt = 0; req_cnt = 0; mis_cnt = 0; berr_cnt = 0;
        ack_memdata = 32'h0; ack_wdata = 32'h0; ack_be = 4'h0; ack_we = 1'b0;
    endtask

    // One EX_MEM entry: d = wait cycles before ack (>TMO means never), iack = ack in the decide cycle (2 random).
    task automatic run_txn(input logic v, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] wa,
                           input logic [1:0] sz, input logic sg, input int d,
                           input logic [31:0] rdat, input int iack);
        logic is_mem, mis, start, ack;
        int   n;
`ifndef DMEM_SUBWORD_EN
        sz = 2'b10;
        sg = 1'b0;
`endif
        n      = nbytes(sz);
        is_mem = v & (rd | wr);
        mis    = is_mem && ((a % n) != 0);
        start  = is_mem && !mis;
        valid_i = v; memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
        wb_i = wb; writeaddr_i = wa;
`ifdef DMEM_SUBWORD_EN
        size_i = sz; sign_i = sg;
`endif
        dmem_ack_i   = (iack == 2) ? ($urandom_range(0, 3) == 0) : (iack == 1);
        dmem_rdata_i = rdat;
        exp_req = 1'b0; exp_we = 1'b0; exp_be = 4'h0; exp_stall = start; exp_memdata = 32'h0;
        exp_mis = mis; exp_berr = 1'b0; exp_wb = mis ? 2'b00 : wb; exp_alu = a; exp_wa = wa;
        @(posedge clk_i); #1;
        if (start) begin
            for (int j = 1; j <= TMO + 1; j++) begin
                ack = (j == d + 1);
                dmem_ack_i   = ack;
                dmem_rdata_i = ack ? rdat : $urandom;
                exp_req     = 1'b1;
                exp_we      = wr;
                exp_addr    = {a[31:2], 2'b00};
                exp_wdata   = ref_wdata(n, wd);
                exp_be      = ref_be(n, a);
                exp_mis     = 1'b0;
                exp_stall   = !ack && (j <= TMO);
                exp_berr    = !ack && (j == TMO + 1);
                exp_memdata = ack ? ref_load(rdat, a, n, sg) : 32'h0;
                exp_wb      = exp_berr ? 2'b00 : wb;
                @(posedge clk_i); #1;
                if (ack || j == TMO + 1) break;
            end
        end
        dmem_ack_i = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rw, rr;
        logic [1:0]  rsz;
        int          rk, rd_d;

        rst_n_i = 1'b0;
        valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        wb_i = 2'b00; writeaddr_i = 5'd0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
`ifdef DMEM_SUBWORD_EN
        size_i = 2'b10; sign_i = 1'b0;
`endif
        clr_mon();
        #1;
        chk("reset_req", 32'(dmem_req_o), 32'h0);
        chk("reset_we", 32'(dmem_we_o), 32'h0);
        chk("reset_be", 32'(dmem_be_o), 32'h0);
        chk("reset_stall", 32'(stall_o), 32'h0);
        chk("reset_err", 32'({misalign_o, bus_err_o}), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i  = 1'b1;
        check_en = 1'b1;

        // load with three wait cycles
        clr_mon();
        run_txn(1, 1, 0, 32'h100, 32'h0, 2'b11, 5'd3, 2'b10, 1'b0, 3, 32'hDEADBEEF, 0);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("lw_memdata", ack_memdata, 32'hDEADBEEF);

        // store with immediate ack
        clr_mon();
        run_txn(1, 0, 1, 32'h204, 32'h12345678, 2'b00, 5'd0, 2'b10, 1'b0, 0, 32'h0, 0);
        chk("sw_stall_cycles", 32'(stall_cnt), 32'd1);
        chk("sw_we", 32'(ack_we), 32'h1);
        chk("sw_be", 32'(ack_be), 32'hF);
        chk("sw_wdata", ack_wdata, 32'h12345678);

        // misaligned word load
        clr_mon();
        run_txn(1, 1, 0, 32'h102, 32'h0, 2'b01, 5'd7, 2'b10, 1'b0, 0, 32'h0, 0);
        chk("mis_pulses", 32'(mis_cnt), 32'd1);
        chk("mis_req", 32'(req_cnt), 32'd0);
        chk("mis_stall", 32'(stall_cnt), 32'd0);

        // no ack ever: timeout, then a normal load
        clr_mon();
        run_txn(1, 1, 0, 32'h400, 32'h0, 2'b10, 5'd4, 2'b10, 1'b0, NO_ACK, 32'h0, 0);
        chk("tmo_bus_err", 32'(berr_cnt), 32'd1);
        chk("tmo_stall_cycles", 32'(stall_cnt), 32'd256);
        clr_mon();
        run_txn(1, 1, 0, 32'h404, 32'h0, 2'b10, 5'd4, 2'b10, 1'b0, 1, 32'h0BADF00D, 0);
        chk("post_tmo_memdata", ack_memdata, 32'h0BADF00D);
        chk("post_tmo_bus_err", 32'(berr_cnt), 32'd0);

        // ack arriving in the timeout cycle wins
        clr_mon();
        run_txn(1, 1, 0, 32'h408, 32'h0, 2'b10, 5'd5, 2'b10, 1'b0, TMO, 32'h55AA55AA, 0);
        chk("edge_bus_err", 32'(berr_cnt), 32'd0);
        chk("edge_memdata", ack_memdata, 32'h55AA55AA);

        // reset in the middle of an access, then a late ack
        valid_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h300; wdata_i = 32'h0;
        wb_i = 2'b10; writeaddr_i = 5'd9; dmem_ack_i = 1'b0;
`ifdef DMEM_SUBWORD_EN
        size_i = 2'b10; sign_i = 1'b0;
`endif
        exp_req = 1'b0; exp_we = 1'b0; exp_be = 4'h0; exp_stall = 1'b1; exp_memdata = 32'h0;
        exp_mis = 1'b0; exp_berr = 1'b0; exp_wb = 2'b10; exp_alu = 32'h300; exp_wa = 5'd9;
        @(posedge clk_i); #1;
        exp_req = 1'b1; exp_be = 4'hF; exp_addr = 32'h300; exp_wdata = 32'h0;
        @(posedge clk_i); #3;
        check_en = 1'b0;
        valid_i  = 1'b0;
        rst_n_i  = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req_o), 32'h0);
        chk("rst_mid_be", 32'(dmem_be_o), 32'h0);
        chk("rst_mid_stall", 32'(stall_o), 32'h0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_n_i  = 1'b1;
        check_en = 1'b1;
        clr_mon();
        run_txn(0, 1, 0, 32'h300, 32'h0, 2'b10, 5'd9, 2'b10, 1'b0, 0, 32'h0, 0);
        run_txn(0, 1, 0, 32'h300, 32'h0, 2'b10, 5'd9, 2'b10, 1'b0, 0, 32'h0, 0);
        run_txn(0, 1, 0, 32'h300, 32'h0, 2'b10, 5'd9, 2'b10, 1'b0, 0, 32'hCAFEF00D, 1);
        chk("late_ack_req", 32'(req_cnt), 32'd0);
        clr_mon();
        run_txn(1, 1, 0, 32'h308, 32'h0, 2'b10, 5'd9, 2'b10, 1'b0, 2, 32'h13579BDF, 0);
        chk("post_rst_memdata", ack_memdata, 32'h13579BDF);

`ifdef DMEM_SUBWORD_EN
        clr_mon();
        run_txn(1, 1, 0, 32'h103, 32'h0, 2'b01, 5'd1, 2'b00, 1'b1, 0, 32'h80FFFFFF, 0);
        chk("lb_memdata", ack_memdata, 32'hFFFFFF80);
        clr_mon();
        run_txn(1, 1, 0, 32'h103, 32'h0, 2'b01, 5'd1, 2'b00, 1'b0, 0, 32'h80FFFFFF, 0);
        chk("lbu_memdata", ack_memdata, 32'h00000080);
        clr_mon();
        run_txn(1, 0, 1, 32'h101, 32'h000000AB, 2'b00, 5'd0, 2'b00, 1'b0, 0, 32'h0, 0);
        chk("sb_be", 32'(ack_be), 32'h2);
        chk("sb_wdata", ack_wdata, 32'hABABABAB);
        clr_mon();
        run_txn(1, 1, 0, 32'h101, 32'h0, 2'b01, 5'd1, 2'b01, 1'b1, 0, 32'h0, 0);
        chk("lh_mis_pulses", 32'(mis_cnt), 32'd1);
`endif

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            rw   = $urandom;
            rr   = $urandom;
            rsz  = 2'($urandom_range(0, 2));
            rk   = $urandom_range(0, 9);
            rd_d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 5);
            run_txn(rk != 0, rk >= 5, (rk >= 1) && (rk < 5), ra, rw, 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), rsz, 1'($urandom_range(0, 1)), rd_d, rr, 2);
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
